// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between an instruction-fetch port and a
// data port. Only one memory transaction is outstanding at a time. Data
// requests win over fetch requests. After every transaction the arbiter
// spends at least one cycle in IDLE.
// Optional feature: define MEM_ARB_ANTI_STARVE_EN to add a 2-bit counter.
// When a waiting fetch has lost to data three times in a row, the next
// grant goes to the fetch port.
module mem_arb (
    input  logic        clk,
    input  logic        rst,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    // memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    // pipeline stalls
    output logic        stall_f,
    output logic        stall_m
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t      state;
    logic        req_r;
    logic        cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        grant_if;
    logic        grant_d;

`ifdef MEM_ARB_ANTI_STARVE_EN
    logic [1:0]  starve_cnt;
    logic        starve_hit;
    assign starve_hit = (starve_cnt == 2'd3);
`endif

    // Grant decision; grants are only made from IDLE
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE) begin
`ifdef MEM_ARB_ANTI_STARVE_EN
            if (if_req && (starve_hit || !d_req)) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else begin
                grant_if = 1'b0;
            end
`else
            if (d_req) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end else begin
                grant_d = 1'b0;
            end
`endif
        end else begin
            grant_if = 1'b0;
        end
    end

    // Arbiter FSM. It latches the granted command and keeps it stable
    // until the memory acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_r     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_be    <= 4'h0;
            cmd_addr  <= 32'h0000_0000;
            cmd_wdata <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= DATA;
                        req_r     <= 1'b1;
                        cmd_we    <= d_we;
                        cmd_be    <= d_be;
                        cmd_addr  <= d_addr;
                        cmd_wdata <= d_wdata;
                    end else if (grant_if) begin
                        state     <= IFETCH;
                        req_r     <= 1'b1;
                        cmd_we    <= 1'b0;
                        cmd_be    <= 4'hF;
                        cmd_addr  <= if_addr;
                        cmd_wdata <= 32'h0000_0000;
                    end else begin
                        state <= IDLE;
                        req_r <= 1'b0;
                    end
                end
                IFETCH, DATA: begin
                    // Finish even if the requester drops its request early
                    if (mem_ack) begin
                        state <= IDLE;
                        req_r <= 1'b0;
                    end else begin
                        state <= state;
                        req_r <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_ANTI_STARVE_EN
    // Count data grants that made a pending fetch wait. Clear on a fetch grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 2'd0;
        end else if (grant_if) begin
            starve_cnt <= 2'd0;
        end else if (grant_d && if_req) begin
            starve_cnt <= starve_cnt + 2'd1;
        end else begin
            starve_cnt <= starve_cnt;
        end
    end
`endif

    assign mem_req   = req_r;
    assign mem_we    = cmd_we;
    assign mem_be    = cmd_be;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    // Acks are forwarded in the same cycle. A stray mem_ack in IDLE is dropped.
    assign if_ack   = mem_ack && (state == IFETCH);
    assign d_ack    = mem_ack && (state == DATA);
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign stall_f  = if_req && !if_ack;
    assign stall_m  = d_req && !d_ack;

endmodule

// File: tb/tb_mem_arb.sv
// Directed, table-driven bench for mem_arb.
// Each table row holds the inputs for one cycle and the outputs expected in
// that cycle. A hand-written sequence then covers the fetch-starvation case.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_f;
    logic        stall_m;

    int errors = 0;
    int checks = 0;

    mem_arb dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_f   (stall_f),
        .stall_m   (stall_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] rdata;
        logic        mack;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_if_ack;
        logic        e_d_ack;
        logic        e_sf;
        logic        e_sm;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic ifr, input logic [31:0] ifa,
                     input logic dr, input logic dwe, input logic [3:0] dbe,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic [31:0] rd, input logic mk,
                     input logic er, input logic ewe, input logic [3:0] ebe,
                     input logic [31:0] ea, input logic [31:0] ewd,
                     input logic eia, input logic eda, input logic esf, input logic esm);
        vec_t t;
        t = '{r, ifr, ifa, dr, dwe, dbe, da, dwd, rd, mk,
              er, ewe, ebe, ea, ewd, eia, eda, esf, esm};
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic ifr, input logic [31:0] ifa,
                         input logic dr, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input logic [31:0] rd, input logic mk);
        rst = r; if_req = ifr; if_addr = ifa; d_req = dr; d_we = dwe;
        d_be = dbe; d_addr = da; d_wdata = dwd; mem_rdata = rd; mem_ack = mk;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [137:0] act, input logic [137:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    logic [137:0] act_bus;
    logic [137:0] exp_bus;
    logic [33:0]  act_g;
    logic [33:0]  exp_g;
    logic         fetch_expected;

    initial begin
        // Rows: rst ifr ifa dr dwe dbe da dwd rdata mack | req we be addr wdata if_ack d_ack stall_f stall_m
        v(1'b1,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b1,          1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0);
        v(1'b1,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b1,        1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,1'b1,1'b0);
        // single fetch
        v(1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,        1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,1'b1,1'b0);
        v(1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,        1'b1,1'b0,4'hF,32'h100,32'h0,1'b0,1'b0,1'b1,1'b0);
        v(1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,32'h00500093,1'b1, 1'b1,1'b0,4'hF,32'h100,32'h0,1'b1,1'b0,1'b0,1'b0);
        v(1'b0,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,          1'b0,1'b0,4'hF,32'h100,32'h0,1'b0,1'b0,1'b0,1'b0);
        // collision: data first, fetch after one idle cycle
        v(1'b0,1'b1,32'h104,1'b1,1'b1,4'h3,32'h2000,32'hDEADBEEF,32'h0,1'b0,        1'b0,1'b0,4'hF,32'h100,32'h0,1'b0,1'b0,1'b1,1'b1);
        v(1'b0,1'b1,32'h104,1'b1,1'b1,4'h3,32'h2000,32'hDEADBEEF,32'h11112222,1'b1, 1'b1,1'b1,4'h3,32'h2000,32'hDEADBEEF,1'b0,1'b1,1'b1,1'b0);
        v(1'b0,1'b1,32'h104,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,        1'b0,1'b1,4'h3,32'h2000,32'hDEADBEEF,1'b0,1'b0,1'b1,1'b0);
        v(1'b0,1'b1,32'h104,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,        1'b1,1'b0,4'hF,32'h104,32'h0,1'b0,1'b0,1'b1,1'b0);
        v(1'b0,1'b1,32'h104,1'b0,1'b0,4'h0,32'h0,32'h0,32'hAABBCCDD,1'b1, 1'b1,1'b0,4'hF,32'h104,32'h0,1'b1,1'b0,1'b0,1'b0);
        v(1'b0,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,          1'b0,1'b0,4'hF,32'h104,32'h0,1'b0,1'b0,1'b0,1'b0);
        // data read with five wait states
        v(1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h3000,32'h0,32'h0,1'b0,       1'b0,1'b0,4'hF,32'h104,32'h0,1'b0,1'b0,1'b0,1'b1);
        for (int i = 0; i < 5; i++)
            v(1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h3000,32'h0,32'h0,1'b0,   1'b1,1'b0,4'hF,32'h3000,32'h0,1'b0,1'b0,1'b0,1'b1);
        v(1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h3000,32'h0,32'hCAFEF00D,1'b1, 1'b1,1'b0,4'hF,32'h3000,32'h0,1'b0,1'b1,1'b0,1'b0);
        // stray ack in IDLE is ignored
        v(1'b0,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b1,          1'b0,1'b0,4'hF,32'h3000,32'h0,1'b0,1'b0,1'b0,1'b0);
        v(1'b0,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,          1'b0,1'b0,4'hF,32'h3000,32'h0,1'b0,1'b0,1'b0,1'b0);
        // reset in the middle of a data write
        v(1'b0,1'b0,32'h0,1'b1,1'b1,4'hF,32'h4000,32'h12345678,32'h0,1'b0, 1'b0,1'b0,4'hF,32'h3000,32'h0,1'b0,1'b0,1'b0,1'b1);
        v(1'b1,1'b0,32'h0,1'b1,1'b1,4'hF,32'h4000,32'h12345678,32'h0,1'b0, 1'b1,1'b1,4'hF,32'h4000,32'h12345678,1'b0,1'b0,1'b0,1'b1);
        v(1'b0,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b1,          1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0);
        v(1'b0,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0,          1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0);

        drive(1'b1,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req,
                  vecs[i].d_we, vecs[i].d_be, vecs[i].d_addr, vecs[i].d_wdata,
                  vecs[i].rdata, vecs[i].mack);
            #1;
            act_bus = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, d_ack,
                       stall_f, stall_m, if_rdata, d_rdata};
            exp_bus = {vecs[i].e_req, vecs[i].e_we, vecs[i].e_be, vecs[i].e_addr,
                       vecs[i].e_wdata, vecs[i].e_if_ack, vecs[i].e_d_ack,
                       vecs[i].e_sf, vecs[i].e_sm, vecs[i].rdata, vecs[i].rdata};
            check("vec", i, act_bus, exp_bus);
        end

        // Fetch held while data is re-requested for four transactions
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            drive(1'b0,1'b1,32'h500,1'b1,1'b0,4'hF,32'h600,32'h0,32'h0,1'b0);
            #1;
            check("starve_idle", t, {137'd0, mem_req}, 138'd0);
            @(negedge clk);
            drive(1'b0,1'b1,32'h500,1'b1,1'b0,4'hF,32'h600,32'h0,32'h0,1'b1);
            #1;
`ifdef MEM_ARB_ANTI_STARVE_EN
            fetch_expected = (t == 3);
`else
            fetch_expected = 1'b0;
`endif
            act_g = {mem_req, mem_addr, if_ack, d_ack};
            exp_g = fetch_expected ? {1'b1, 32'h500, 1'b1, 1'b0}
                                   : {1'b1, 32'h600, 1'b0, 1'b1};
            check("starve_grant", t, {104'd0, act_g}, {104'd0, exp_g});
        end

        @(negedge clk);
        drive(1'b0,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,1'b0);
        #1;
        check("final_idle", 0, {136'd0, mem_req, stall_f}, 138'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
